// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory bus port between the fetch stage (instruction reads) and
// the memory stage (loads/stores). Grants one requester in IDLE, latches its
// request into the bus registers, runs a valid/ready handshake, waits for the
// bus response and returns it to the owner as a one-cycle rvalid pulse.
// Only one transaction is ever outstanding.
//
// Ports:
//   i_clk, i_arst                 clock, synchronous active-high reset
//   i_if_req/addr/kill            fetch request, address, pipeline redirect
//   o_if_gnt/rvalid/rdata         fetch grant (combinational), response
//   i_dm_req/we/addr/wdata        data request
//   o_dm_gnt/rvalid/rdata         data grant (combinational), response
//   o_bus_valid/addr/we/wdata     bus request, i_bus_ready accepts it
//   i_bus_rvalid/rdata            bus response
//   o_busy, o_owner               FSM not idle, current owner (1 = data)
//
// Configuration macro: MEM_ARB_FAIR_EN
//   defined   - after MAX_D_GRANTS consecutive data grants made while fetch
//               waits, fetch wins the next simultaneous request
//   undefined - strict data priority, no counter

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned MAX_D_GRANTS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    input  logic                  i_if_kill,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    input  logic [DATA_WIDTH-1:0] i_dm_wdata,
    output logic                  o_dm_gnt,
    output logic                  o_dm_rvalid,
    output logic [DATA_WIDTH-1:0] o_dm_rdata,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic                  o_bus_we,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_busy,
    output logic                  o_owner
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    if (MAX_D_GRANTS == 0) begin : g_bad_max_d_grants
        $error("mem_port_arbiter: MAX_D_GRANTS must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic                  bus_valid_q, bus_valid_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  owner_q, owner_d;
    logic                  killed_q, killed_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic in_idle;
    logic fetch_wins;
    logic dm_gnt;
    logic if_gnt;

    assign in_idle = (state_q == StIdle);

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CntW = $clog2(MAX_D_GRANTS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_D_GRANTS);

    logic [CntW-1:0] fair_cnt_q, fair_cnt_d;

    // Fetch only overrides data priority once it has been starved long enough.
    assign fetch_wins = i_if_req & i_dm_req & (fair_cnt_q == CntMax);

    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (if_gnt) begin
            fair_cnt_d = '0;
        end else if (dm_gnt && i_if_req && (fair_cnt_q != CntMax)) begin
            fair_cnt_d = fair_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            fair_cnt_q <= '0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end
`else
    assign fetch_wins = 1'b0;
`endif

    assign dm_gnt = in_idle & i_dm_req & ~fetch_wins;
    assign if_gnt = in_idle & i_if_req & ~dm_gnt;

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        owner_d     = owner_q;
        killed_d    = killed_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (dm_gnt || if_gnt) begin
                    state_d     = StIssue;
                    bus_valid_d = 1'b1;
                    owner_d     = dm_gnt;
                    bus_addr_d  = dm_gnt ? i_dm_addr : i_if_addr;
                    bus_we_d    = dm_gnt & i_dm_we;
                    bus_wdata_d = dm_gnt ? i_dm_wdata : '0;
                end
            end
            StIssue: begin
                if (!owner_q && i_if_kill) begin
                    killed_d = 1'b1;
                end
                // A response here would violate the protocol; it is dropped.
                if (i_bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (!owner_q && i_if_kill) begin
                    killed_d = 1'b1;
                end
                if (i_bus_rvalid) begin
                    state_d = StResp;
                    if (owner_q) begin
                        dm_rdata_d  = i_bus_rdata;
                        dm_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = i_bus_rdata;
                        if_rvalid_d = ~(killed_q | i_if_kill);
                    end
                end
            end
            StResp: begin
                state_d  = StIdle;
                killed_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            owner_q     <= 1'b0;
            killed_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            owner_q     <= owner_d;
            killed_q    <= killed_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_dm_gnt    = dm_gnt;
    // A redirect arriving in the response cycle itself still cancels the pulse.
    assign o_if_rvalid = if_rvalid_q & ~i_if_kill;
    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rvalid = dm_rvalid_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_bus_valid = bus_valid_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_busy      = ~in_idle;
    assign o_owner     = owner_q;

endmodule
